pulse_stretcher: RTL and testbench
==================================

// Module: pulse_stretcher
//
// PURPOSE
//   Converts one-clock-wide pulses back into fixed-length level windows; the
//   inverse of edge_detector (pulse in, timed level out). Each bit is an
//   independent channel: a pulse yields exactly HIGH_CYCLES high cycles, then
//   at least GAP_CYCLES low cycles. Used to drive LEDs/status/handshake levels
//   from event pulses (e.g. edge_detector outputs) in the SoC periphery.
//
// PARAMETERS
//   WIDTH        1   number of independent channels
//   HIGH_CYCLES  10  level_out high time per pulse, in clk cycles (>=1)
//   GAP_CYCLES   1   minimum low time between two windows, in clk cycles (>=1)
//   CNT_W        localparam, $clog2(max(HIGH_CYCLES,GAP_CYCLES)+1)
//
// PORTS
//   clk        in   1      clock
//   rst        in   1      reset, asynchronous, active-high
//   pulse_in   in   WIDTH  event pulses; every high cycle counts as one event
//   level_out  out  WIDTH  stretched level, registered
//   busy       out  WIDTH  channel not IDLE (HIGH or GAP), registered
//   overflow   out  WIDTH  sticky: an event was dropped; cleared only by rst
//
// BEHAVIOUR (per channel; all outputs registered)
//   - Reset: asynchronous, active-high; state=IDLE, cnt=0, pending=0;
//     level_out=0, busy=0, overflow=0 immediately, no clock edge needed.
//   - States: IDLE, HIGH, GAP.
//   - IDLE: pulse_in=1 at posedge -> HIGH, cnt=HIGH_CYCLES-1; level_out=1 after
//     that same edge (latency 1 clk from sampled pulse).
//   - HIGH: cnt decrements each edge; at cnt==0 -> GAP, cnt=GAP_CYCLES-1,
//     level_out=0. level_out is high for exactly HIGH_CYCLES edges.
//   - GAP: cnt decrements; at cnt==0 -> HIGH (cnt reload) if pending, clearing
//     pending; else -> IDLE. level_out low for exactly GAP_CYCLES edges.
//   - Pulse in HIGH (incl. cnt==0 edge) or GAP: pending=0 -> pending=1;
//     pending=1 -> event dropped, overflow=1. At most one queued event.
//   - Pulse on the GAP->IDLE edge: pending set is skipped; channel goes
//     directly to HIGH (treated as IDLE pulse).
//   - pulse_in held high N cycles = N events (no internal edge detection).
//   - Reset mid-window: window aborted, pending and overflow discarded.
//   - busy = (state != IDLE); channels share no state.
//
// CONFIGURATION
//   PULSE_STRETCHER_RETRIGGER_EN
//   - defined: pulse in HIGH (incl. cnt==0 edge) reloads cnt=HIGH_CYCLES-1,
//     extending the window to HIGH_CYCLES after the latest pulse; it never
//     sets pending/overflow. Pulses in GAP behave as above.
//   - undefined: all pulses in HIGH/GAP queue via pending as above.
//
// STRUCTURE
//   - Shared package/include: state encoding localparams (PS_IDLE=2'd0,
//     PS_HIGH=2'd1, PS_GAP=2'd2) and the CNT_W width function.
//   - Sub-module pulse_stretcher_ch: one channel (FSM, counter, pending,
//     overflow); top generates WIDTH instances, no cross-channel logic.
//
// TESTING (clk 10 ns; WIDTH=1, HIGH_CYCLES=10, GAP_CYCLES=1 unless noted)
//   1 rst high 2 clks, pulse_in=0 -> level_out/busy/overflow=0 during+after.
//   2 1-clk pulse -> level_out high for exactly 10 posedges, then low; busy
//     high 11 cycles; overflow stays 0.
//   3 2nd pulse 4 clks into window -> undefined: 10 high, 1 low, 10 high;
//     defined (RETRIGGER_EN): 14 high continuous, then 1 low, idle.
//   4 (macro undefined) 3 pulses in one window -> overflow=1 after 3rd
//     sampled edge; exactly two 10-clk windows separated by 1 low clk.
//   5 rst asserted 5 clks into window, between edges -> level_out=0 within
//     #1, no edge; after release a fresh pulse reproduces test 2.
//   6 WIDTH=2: pulse bit0 at t0, bit1 at t0+3 clks -> windows offset by 3
//     clks, each exactly 10 high; no interaction.

Source files
------------

// File: rtl/pulse_stretcher_pkg.sv
// Shared definitions for pulse_stretcher: channel state encoding and counter sizing.
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    PS_IDLE = 2'd0,
    PS_HIGH = 2'd1,
    PS_GAP  = 2'd2
  } ps_state_e;

  // Counter must hold the larger of the two reload values (HIGH_CYCLES-1, GAP_CYCLES-1).
  function automatic int ps_cnt_width(input int high_cycles, input int gap_cycles);
    int max_cycles;
    max_cycles = (high_cycles > gap_cycles) ? high_cycles : gap_cycles;
    return (max_cycles < 1) ? 1 : $clog2(max_cycles + 1);
  endfunction

endpackage

// File: rtl/pulse_stretcher_ch.sv
// One pulse_stretcher channel: IDLE/HIGH/GAP FSM, down-counter, one-deep event queue.
// Build option: PULSE_STRETCHER_RETRIGGER_EN (pulses during HIGH extend the window).
module pulse_stretcher_ch
  import pulse_stretcher_pkg::*;
#(
  parameter int HIGH_CYCLES = 10,
  parameter int GAP_CYCLES  = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pulse,
  output logic o_level,
  output logic o_busy,
  output logic o_overflow
);

  localparam int CNT_W = ps_cnt_width(HIGH_CYCLES, GAP_CYCLES);
  localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  ps_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pending;
  logic             r_level;
  logic             r_busy;
  logic             r_overflow;

  ps_state_e        w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_pending_nxt;
  logic             w_overflow_nxt;
  logic             w_queue;
  logic             w_cnt_zero;

  assign w_cnt_zero = (r_cnt == '0);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_pending_nxt  = r_pending;
    w_overflow_nxt = r_overflow;
    w_queue        = 1'b0;

    case (r_state)
      PS_IDLE: begin
        if (i_pulse) begin
          w_state_nxt = PS_HIGH;
          w_cnt_nxt   = HIGH_LOAD;
        end
      end

      PS_HIGH: begin
        if (w_cnt_zero) begin
          w_state_nxt = PS_GAP;
          w_cnt_nxt   = GAP_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
`ifdef PULSE_STRETCHER_RETRIGGER_EN
        if (i_pulse) begin
          w_state_nxt = PS_HIGH;
          w_cnt_nxt   = HIGH_LOAD;
        end
`else
        w_queue = i_pulse;
`endif
      end

      PS_GAP: begin
        if (w_cnt_zero) begin
          if (r_pending) begin
            w_state_nxt   = PS_HIGH;
            w_cnt_nxt     = HIGH_LOAD;
            w_pending_nxt = 1'b0;
            w_queue       = i_pulse;
          end else if (i_pulse) begin
            // Window ends on the same edge: behave exactly like a pulse seen in IDLE.
            w_state_nxt = PS_HIGH;
            w_cnt_nxt   = HIGH_LOAD;
          end else begin
            w_state_nxt = PS_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
          w_queue   = i_pulse;
        end
      end

      default: begin
        w_state_nxt = PS_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    // Queue test uses the registered pending bit: an event already waiting always wins.
    if (w_queue) begin
      if (r_pending) w_overflow_nxt = 1'b1;
      else           w_pending_nxt  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= PS_IDLE;
      r_cnt      <= '0;
      r_pending  <= 1'b0;
      r_level    <= 1'b0;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_pending  <= w_pending_nxt;
      r_level    <= (w_state_nxt == PS_HIGH);
      r_busy     <= (w_state_nxt != PS_IDLE);
      r_overflow <= w_overflow_nxt;
    end
  end

  assign o_level    = r_level;
  assign o_busy     = r_busy;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/pulse_stretcher.sv
// Pulse stretcher top: WIDTH independent channels turning event pulses into timed level windows.
// Build option: PULSE_STRETCHER_RETRIGGER_EN (see pulse_stretcher_ch).
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int HIGH_CYCLES = 10,
  parameter int GAP_CYCLES  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pulse_in,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] busy,
  output logic [WIDTH-1:0] overflow
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    pulse_stretcher_ch #(
      .HIGH_CYCLES(HIGH_CYCLES),
      .GAP_CYCLES (GAP_CYCLES)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .i_pulse   (pulse_in[g]),
      .o_level   (level_out[g]),
      .o_busy    (busy[g]),
      .o_overflow(overflow[g])
    );
  end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher (WIDTH=2, HIGH_CYCLES=10, GAP_CYCLES=1).
module tb_pulse_stretcher;
  import pulse_stretcher_pkg::*;

  localparam int W    = 2;
  localparam int NCYC = 40;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] pulse_in = '0;
  logic [W-1:0] level_out;
  logic [W-1:0] busy;
  logic [W-1:0] overflow;

  int n_tests = 0;
  int n_fail  = 0;

  logic [NCYC-1:0] stim0, stim1;
  logic [NCYC-1:0] lv0, lv1, bz0, ov0;

  pulse_stretcher #(
    .WIDTH(W), .HIGH_CYCLES(10), .GAP_CYCLES(1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pulse_in (pulse_in),
    .level_out(level_out),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Bits [lo, hi) set: sample i is taken 1 ns after the i-th edge of a run.
  function automatic logic [NCYC-1:0] win(input int lo, input int hi);
    logic [NCYC-1:0] m;
    m = '0;
    for (int i = 0; i < NCYC; i++) if (i >= lo && i < hi) m[i] = 1'b1;
    return m;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive stim on each edge (set up just after the previous edge), sample 1 ns after it.
  task automatic run();
    for (int i = 0; i < NCYC; i++) begin
      pulse_in = {stim1[i], stim0[i]};
      @(posedge clk);
      #1;
      lv0[i] = level_out[0];
      lv1[i] = level_out[1];
      bz0[i] = busy[0];
      ov0[i] = overflow[0];
    end
    pulse_in = '0;
  endtask

  initial begin
    // 1: reset held two clocks, then released with no pulses.
    #1;
    check("rst_during_level", 64'(level_out), 64'(0));
    check("rst_during_busy", 64'(busy), 64'(0));
    check("rst_during_ovf", 64'(overflow), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_after_level", 64'(level_out), 64'(0));
    check("rst_after_busy", 64'(busy), 64'(0));
    check("rst_after_ovf", 64'(overflow), 64'(0));

    // 2: single pulse -> 10 high, busy 11.
    stim0 = '0; stim1 = '0; stim0[0] = 1'b1;
    run();
    check("single_level", 64'(lv0), 64'(win(0, 10)));
    check("single_busy", 64'(bz0), 64'(win(0, 11)));
    check("single_ovf", 64'(ov0), 64'(0));
    check("single_ch1_quiet", 64'(lv1), 64'(0));

    // 3: second pulse four clocks into the window.
    stim0 = '0; stim0[0] = 1'b1; stim0[4] = 1'b1;
    run();
`ifdef PULSE_STRETCHER_RETRIGGER_EN
    check("second_level", 64'(lv0), 64'(win(0, 14)));
    check("second_busy", 64'(bz0), 64'(win(0, 15)));
`else
    check("second_level", 64'(lv0), 64'(win(0, 10) | win(11, 21)));
    check("second_busy", 64'(bz0), 64'(win(0, 22)));
`endif
    check("second_ovf", 64'(ov0), 64'(0));

    // 4: three pulses in one window -> third is dropped (queued mode).
    stim0 = '0; stim0[0] = 1'b1; stim0[2] = 1'b1; stim0[4] = 1'b1;
    run();
`ifdef PULSE_STRETCHER_RETRIGGER_EN
    check("triple_level", 64'(lv0), 64'(win(0, 14)));
    check("triple_ovf", 64'(ov0), 64'(0));
`else
    check("triple_level", 64'(lv0), 64'(win(0, 10) | win(11, 21)));
    check("triple_ovf", 64'(ov0), 64'(win(4, NCYC)));
`endif

    // Pulse held high three cycles = three events (queued mode drops the third).
    stim0 = '0; stim0[0] = 1'b1; stim0[1] = 1'b1; stim0[2] = 1'b1;
    rst = 1'b1; #1; rst = 1'b0;
    run();
`ifdef PULSE_STRETCHER_RETRIGGER_EN
    check("held_level", 64'(lv0), 64'(win(0, 12)));
    check("held_ovf", 64'(ov0), 64'(0));
`else
    check("held_level", 64'(lv0), 64'(win(0, 10) | win(11, 21)));
    check("held_ovf", 64'(ov0), 64'(win(2, NCYC)));
`endif

    // 5: asynchronous reset mid-window, between clock edges.
    pulse_in = 2'b01;
    @(posedge clk); #1;
    pulse_in = '0;
    repeat (5) @(posedge clk);
    #3;
    check("pre_rst_level", 64'(level_out), 64'(1));
    rst = 1'b1;
    #1;
    check("async_rst_level", 64'(level_out), 64'(0));
    check("async_rst_busy", 64'(busy), 64'(0));
    check("async_rst_ovf", 64'(overflow), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    stim0 = '0; stim1 = '0; stim0[0] = 1'b1;
    run();
    check("post_rst_level", 64'(lv0), 64'(win(0, 10)));
    check("post_rst_busy", 64'(bz0), 64'(win(0, 11)));

    // 6: two channels offset by three clocks.
    stim0 = '0; stim1 = '0; stim0[0] = 1'b1; stim1[3] = 1'b1;
    run();
    check("dual_ch0_level", 64'(lv0), 64'(win(0, 10)));
    check("dual_ch1_level", 64'(lv1), 64'(win(3, 13)));
    check("dual_ovf", 64'(overflow), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
